// File: rtl/i2c_eeprom_slave.sv
// 24xx-style I2C EEPROM target: 7-bit address match, 16-bit word pointer, byte/sequential
// write, current-address read and random read. SCL is never driven (no clock stretching).
module i2c_eeprom_slave #(
  parameter logic [6:0] ADDRESS   = 7'b1010_000,
  parameter int         MEM_DEPTH = 1024
) (
  input  logic clk,
  input  logic rst_ni,
  inout  wire  scl_io,
  inout  wire  sda_io,
  output logic busy_o
);

  localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  typedef enum logic [3:0] {
    IDLE, DEV, DEV_ACK, AHI, AHI_ACK, ALO, ALO_ACK, WR, WR_ACK, RD, RD_ACK
  } state_e;

  state_e        state_q, state_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    ptr_hi_q, ptr_hi_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic          rw_q, rw_d;
  logic          sda_oe_q, sda_oe_d;
  logic          busy_q, busy_d;

  // [0],[1] synchronizer, [2] one-cycle delayed copy for edge detection
  logic [2:0]    scl_q, sda_q;

  logic [7:0]    mem [MEM_DEPTH];
  logic [7:0]    mem_rdata, shift_in;
  logic          mem_we;
  logic [AW-1:0] ptr_inc;

  logic scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det;

  assign scl_s     = scl_q[1];
  assign sda_s     = sda_q[1];
  assign scl_rise  =  scl_s & ~scl_q[2];
  assign scl_fall  = ~scl_s &  scl_q[2];
  assign start_det =  scl_s & scl_q[2] &  sda_q[2] & ~sda_s;
  assign stop_det  =  scl_s & scl_q[2] & ~sda_q[2] &  sda_s;

  assign shift_in  = {shift_q[6:0], sda_s};
  assign mem_rdata = mem[ptr_q];
  assign ptr_inc   = (ptr_q == AW'(MEM_DEPTH - 1)) ? '0 : ptr_q + AW'(1);

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      scl_q <= 3'b111;
      sda_q <= 3'b111;
    end else begin
      scl_q <= {scl_q[1:0], scl_io};
      sda_q <= {sda_q[1:0], sda_io};
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    ptr_hi_d  = ptr_hi_q;
    ptr_d     = ptr_q;
    rw_d      = rw_q;
    sda_oe_d  = sda_oe_q;
    busy_d    = busy_q;
    mem_we    = 1'b0;
    if (stop_det) begin
      state_d   = IDLE;
      bit_cnt_d = '0;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b0;
    end else if (start_det) begin
      state_d   = DEV;
      bit_cnt_d = '0;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: ;
        DEV, AHI, ALO, WR: begin
          if (scl_rise) begin
            shift_d   = shift_in;
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              bit_cnt_d = '0;
              unique case (state_q)
                DEV: begin
                  if (shift_q[6:0] == ADDRESS) begin
                    rw_d    = sda_s;
                    state_d = DEV_ACK;
                  end else begin
                    state_d = IDLE;
                  end
                end
                AHI: begin
                  ptr_hi_d = shift_in;
                  state_d  = AHI_ACK;
                end
                ALO: begin
                  ptr_d   = AW'({ptr_hi_q, shift_in} % MEM_DEPTH);
                  state_d = ALO_ACK;
                end
                default: begin
                  mem_we  = 1'b1;
                  ptr_d   = ptr_inc;
                  state_d = WR_ACK;
                end
              endcase
            end
          end
        end
        // first falling edge pulls SDA for the ACK, the second releases it
        DEV_ACK, AHI_ACK, ALO_ACK, WR_ACK: begin
          if (scl_fall) begin
            if (!sda_oe_q) begin
              sda_oe_d = 1'b1;
              if (state_q == DEV_ACK) busy_d = 1'b1;
            end else begin
              sda_oe_d  = 1'b0;
              bit_cnt_d = '0;
              unique case (state_q)
                DEV_ACK: begin
                  if (rw_q) begin
                    shift_d  = mem_rdata;
                    sda_oe_d = ~mem_rdata[7];
                    state_d  = RD;
                  end else begin
                    state_d  = AHI;
                  end
                end
                AHI_ACK: state_d = ALO;
                default: state_d = WR;
              endcase
            end
          end
        end
        RD: begin
          if (scl_rise) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall) begin
            if (bit_cnt_q == 4'd8) begin
              sda_oe_d  = 1'b0;
              ptr_d     = ptr_inc;
              bit_cnt_d = '0;
              state_d   = RD_ACK;
            end else begin
              sda_oe_d = ~shift_q[3'd7 - bit_cnt_q[2:0]];
            end
          end
        end
        RD_ACK: begin
          // a falling edge here always follows a sampled ACK; NACK has already left
          if (scl_rise) begin
            if (sda_s) begin
              state_d = IDLE;
              busy_d  = 1'b0;
            end
          end else if (scl_fall) begin
            shift_d   = mem_rdata;
            sda_oe_d  = ~mem_rdata[7];
            bit_cnt_d = '0;
            state_d   = RD;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      ptr_hi_q  <= '0;
      ptr_q     <= '0;
      rw_q      <= 1'b0;
      sda_oe_q  <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      ptr_hi_q  <= ptr_hi_d;
      ptr_q     <= ptr_d;
      rw_q      <= rw_d;
      sda_oe_q  <= sda_oe_d;
      busy_q    <= busy_d;
    end
  end

  // memory keeps its contents across reset
  always_ff @(posedge clk) begin
    if (mem_we) mem[ptr_q] <= shift_in;
  end

  assign sda_io = sda_oe_q ? 1'b0 : 1'bz;
  assign busy_o = busy_q;

endmodule

// File: tb/tb_i2c_eeprom_slave.sv
// Directed bench: bit-banged I2C master drives the EEPROM target and checks ACKs and data.
module tb_i2c_eeprom_slave;

  localparam int Q = 100;

  logic clk = 1'b0;
  logic rst_n;
  logic scl_drv, sda_low;
  logic busy;
  logic mon_en;
  int   pulls, busy_hits;
  int   checks, fails;
  wire  scl_bus, sda_bus;

  always #5 clk = ~clk;

  assign scl_bus = scl_drv;
  assign sda_bus = sda_low ? 1'b0 : 1'bz;
  pullup (sda_bus);

  i2c_eeprom_slave dut (
    .clk   (clk),
    .rst_ni(rst_n),
    .scl_io(scl_bus),
    .sda_io(sda_bus),
    .busy_o(busy)
  );

  always @(negedge clk) begin
    if (mon_en && !sda_low && sda_bus == 1'b0) pulls++;
    if (mon_en && busy) busy_hits++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic i2c_start();
    sda_low = 1'b0; #(Q);
    scl_drv = 1'b1; #(Q);
    sda_low = 1'b1; #(Q);
    scl_drv = 1'b0; #(Q);
  endtask

  task automatic i2c_stop();
    sda_low = 1'b1; #(Q);
    scl_drv = 1'b1; #(Q);
    sda_low = 1'b0; #(Q);
  endtask

  task automatic send_bit(input logic b);
    sda_low = ~b;   #(Q);
    scl_drv = 1'b1; #(2*Q);
    scl_drv = 1'b0; #(Q);
  endtask

  task automatic recv_bit(output logic b);
    sda_low = 1'b0; #(Q);
    scl_drv = 1'b1; #(Q);
    b = sda_bus;    #(Q);
    scl_drv = 1'b0; #(Q);
  endtask

  task automatic wb(input logic [7:0] d, output logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    recv_bit(b);
    ack = ~b;
  endtask

  task automatic rb(input logic ack, output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      recv_bit(b);
      d[i] = b;
    end
    send_bit(~ack);
  endtask

  // START, device write, pointer hi/lo; bus left with SCL low after the last ACK
  task automatic set_ptr(input logic [15:0] a);
    logic ack;
    i2c_start();
    wb(8'hA0, ack);   chk("ptr_dev_ack", ack, 1);
    wb(a[15:8], ack); chk("ptr_hi_ack", ack, 1);
    wb(a[7:0], ack);  chk("ptr_lo_ack", ack, 1);
  endtask

  initial begin
    logic       ack;
    logic [7:0] d;
    checks = 0; fails = 0; pulls = 0; busy_hits = 0;
    scl_drv = 1'b1; sda_low = 1'b0; mon_en = 1'b0; rst_n = 1'b0;
    #(Q);
    chk("rst_busy", busy, 0);
    chk("rst_sda", sda_bus, 1);
    rst_n = 1'b1; #(Q);

    // sequential write 5A A5 C3 at 0x0010
    i2c_start();
    wb(8'hA0, ack); chk("wr_dev_ack", ack, 1);
    chk("wr_busy", busy, 1);
    wb(8'h00, ack); chk("wr_hi_ack", ack, 1);
    wb(8'h10, ack); chk("wr_lo_ack", ack, 1);
    wb(8'h5A, ack); chk("wr_d0_ack", ack, 1);
    wb(8'hA5, ack); chk("wr_d1_ack", ack, 1);
    wb(8'hC3, ack); chk("wr_d2_ack", ack, 1);
    i2c_stop();
    chk("wr_stop_busy", busy, 0);

    // random read of two bytes, then current-address read continues at 0x12
    set_ptr(16'h0010);
    i2c_start();
    wb(8'hA1, ack); chk("rr_dev_ack", ack, 1);
    rb(1'b1, d);    chk("rr_b0", d, 8'h5A);
    rb(1'b0, d);    chk("rr_b1", d, 8'hA5);
    chk("rr_nack_busy", busy, 0);
    i2c_stop();
    i2c_start();
    wb(8'hA1, ack); chk("cr_dev_ack", ack, 1);
    rb(1'b0, d);    chk("cr_b0", d, 8'hC3);
    i2c_stop();

    // foreign address: target must stay silent and write nothing
    mon_en = 1'b1;
    i2c_start();
    wb(8'hA2, ack); chk("mm_dev_ack", ack, 0);
    wb(8'h00, ack); chk("mm_hi_ack", ack, 0);
    wb(8'h10, ack); chk("mm_lo_ack", ack, 0);
    wb(8'hFF, ack); chk("mm_d_ack", ack, 0);
    i2c_stop();
    mon_en = 1'b0;
    chk("mm_sda_pulls", pulls, 0);
    chk("mm_busy_hits", busy_hits, 0);
    set_ptr(16'h0010);
    i2c_start();
    wb(8'hA1, ack); rb(1'b0, d); chk("mm_mem_keep", d, 8'h5A);
    i2c_stop();

    // pointer wrap at the top of memory
    set_ptr(16'h03FF);
    wb(8'h11, ack); chk("wrap_d0_ack", ack, 1);
    wb(8'h22, ack); chk("wrap_d1_ack", ack, 1);
    wb(8'h33, ack); chk("wrap_d2_ack", ack, 1);
    i2c_stop();
    set_ptr(16'h03FF);
    i2c_start();
    wb(8'hA1, ack);
    rb(1'b1, d); chk("wrap_3ff", d, 8'h11);
    rb(1'b1, d); chk("wrap_000", d, 8'h22);
    rb(1'b0, d); chk("wrap_001", d, 8'h33);
    i2c_stop();

    // STOP inside a data byte discards it
    set_ptr(16'h0010);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    i2c_stop();
    set_ptr(16'h0010);
    i2c_start();
    wb(8'hA1, ack); chk("part_restart_ack", ack, 1);
    rb(1'b0, d);    chk("part_mem_keep", d, 8'h5A);
    i2c_stop();

    // reset while the target drives a 0 data bit (MSB of 0x5A)
    set_ptr(16'h0010);
    i2c_start();
    wb(8'hA1, ack);
    chk("rrst_msb_low", sda_bus, 0);
    chk("rrst_busy_pre", busy, 1);
    rst_n = 1'b0; #1;
    chk("rrst_sda_rel", sda_bus, 1);
    chk("rrst_busy", busy, 0);
    #(Q-1);
    rst_n = 1'b1; #(Q);
    i2c_stop();
    i2c_start();
    wb(8'hA1, ack); chk("rrst_dev_ack", ack, 1);
    rb(1'b0, d);    chk("rrst_ptr0", d, 8'h22);
    i2c_stop();

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
